// File: rtl/mul_sched_pkg.sv
// Shared types for the round-robin multiplier scheduler: operand/product
// widths, the in-flight tag and the queued response record.
package mul_sched_pkg;

    localparam int DATA_W   = 16;
    localparam int PROD_W   = 32;
    // Wide enough for the largest supported requester count (16).
    localparam int ID_W_MAX = 4;

    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic [PROD_W-1:0]   data;
    } rsp_t;

endpackage

// File: rtl/mul_rsp_fifo.sv
// Response FIFO with a registered head entry; a push into an empty FIFO
// bypasses storage and lands directly in the head register.
module mul_rsp_fifo
    import mul_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  rsp_t                     push_data,
    input  logic                     pop,
    output logic                     out_valid,
    output rsp_t                     out_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rsp_t             mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] mem_cnt_r;
    logic             head_valid_r;
    rsp_t             head_r;

    logic pop_s;
    logic take_s;
    logic mem_nonempty_s;
    logic load_s;
    logic bypass_s;
    logic wr_s;

    // Decide where this cycle's push goes and whether the head reloads.
    always_comb begin
        pop_s          = pop & head_valid_r;
        take_s         = ~head_valid_r | pop_s;
        mem_nonempty_s = (mem_cnt_r != {CNT_W{1'b0}});
        load_s         = take_s & mem_nonempty_s;
        bypass_s       = take_s & ~mem_nonempty_s & push;
        wr_s           = push & ~bypass_s;
    end

    // Storage array; contents need no reset because the count gates reads.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, storage count and the registered head entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            mem_cnt_r    <= {CNT_W{1'b0}};
            head_valid_r <= 1'b0;
            head_r       <= '0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (load_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({wr_s, load_s})
                2'b10:   mem_cnt_r <= mem_cnt_r + CNT_W'(1);
                2'b01:   mem_cnt_r <= mem_cnt_r - CNT_W'(1);
                default: mem_cnt_r <= mem_cnt_r;
            endcase
            if (take_s) begin
                head_valid_r <= load_s | bypass_s;
                if (load_s) begin
                    head_r <= mem_r[rd_ptr_r];
                end else if (bypass_s) begin
                    head_r <= push_data;
                end else begin
                    head_r <= head_r;
                end
            end else begin
                head_valid_r <= head_valid_r;
                head_r       <= head_r;
            end
        end
    end

    assign out_valid = head_valid_r;
    assign out_data  = head_r;
    assign count     = mem_cnt_r + {{(CNT_W-1){1'b0}}, head_valid_r};
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = ~head_valid_r;

endmodule

// File: rtl/mul_rr_scheduler.sv
// Round-robin front end sharing one pipelined signed multiplier among N_REQ
// requesters; products return tagged and in issue order through a FIFO.
module mul_rr_scheduler
    import mul_sched_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int MUL_LAT    = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*DATA_W-1:0]    req_a,
    input  logic [N_REQ*DATA_W-1:0]    req_b,
    output logic [DATA_W-1:0]          mul_a,
    output logic [DATA_W-1:0]          mul_b,
    input  logic [PROD_W-1:0]          mul_c,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [PROD_W-1:0]          rsp_data,
    output logic                       busy
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ID_W-1:0]  last_grant_r;
    logic [CNT_W-1:0] outstanding_r;
    tag_t             tag_r [MUL_LAT+1];

    logic             found_s;
    logic [ID_W-1:0]  win_s;
    logic [ID_W:0]    sum_s;
    logic [ID_W:0]    cand_s;
    logic             hit_s;
    logic             credit_ok_s;
    logic             grant_s;
    logic             accept_s;
    logic             pop_s;
    rsp_t             push_data_s;
    rsp_t             head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_unused_s;

    // Rotating priority search starting just after the last winner.
    always_comb begin
        found_s = 1'b0;
        win_s   = {ID_W{1'b0}};
        sum_s   = {(ID_W+1){1'b0}};
        cand_s  = {(ID_W+1){1'b0}};
        hit_s   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum_s   = {1'b0, last_grant_r} + (ID_W+1)'(k);
            cand_s  = (sum_s >= (ID_W+1)'(N_REQ)) ? (sum_s - (ID_W+1)'(N_REQ)) : sum_s;
            hit_s   = ~found_s & req_valid[cand_s[ID_W-1:0]];
            win_s   = hit_s ? cand_s[ID_W-1:0] : win_s;
            found_s = found_s | hit_s;
        end
    end

    // Credit bounds outstanding work by FIFO capacity; ready is low in reset.
    always_comb begin
        credit_ok_s = (outstanding_r < CNT_W'(FIFO_DEPTH));
        grant_s     = found_s & credit_ok_s & rst;
        req_ready   = {N_REQ{1'b0}};
        if (grant_s) begin
            req_ready[win_s] = 1'b1;
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
        accept_s = |(req_valid & req_ready);
        pop_s    = rsp_valid & rsp_ready;
    end

    // Round-robin pointer and outstanding-operation credit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_r  <= ID_W'(N_REQ - 1);
            outstanding_r <= {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                last_grant_r <= win_s;
            end else begin
                last_grant_r <= last_grant_r;
            end
            case ({accept_s, pop_s})
                2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
                2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Operand issue and the id tag pipe that tracks the multiplier latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a <= {DATA_W{1'b0}};
            mul_b <= {DATA_W{1'b0}};
            for (int i = 0; i <= MUL_LAT; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            if (accept_s) begin
                mul_a    <= req_a[int'(win_s)*DATA_W +: DATA_W];
                mul_b    <= req_b[int'(win_s)*DATA_W +: DATA_W];
                tag_r[0] <= '{valid: 1'b1, id: ID_W_MAX'(win_s)};
            end else begin
                mul_a    <= {DATA_W{1'b0}};
                mul_b    <= {DATA_W{1'b0}};
                tag_r[0] <= '0;
            end
            for (int i = 1; i <= MUL_LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    assign push_data_s = '{id: tag_r[MUL_LAT].id, data: mul_c};

    mul_rsp_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .push       (tag_r[MUL_LAT].valid),
        .push_data  (push_data_s),
        .pop        (pop_s),
        .out_valid  (rsp_valid),
        .out_data   (head_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .count      (fifo_count_s)
    );

    assign rsp_id        = head_s.id[ID_W-1:0];
    assign rsp_data      = head_s.data;
    assign busy          = (outstanding_r != {CNT_W{1'b0}});
    assign fifo_unused_s = ^{fifo_full_s, fifo_empty_s, fifo_count_s, head_s.id};

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Randomized bench for mul_rr_scheduler: a queue-based model predicts grants,
// response timing and values; a behavioural multiplier closes the loop.
module tb_mul_rr_scheduler;

    localparam int N     = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*16-1:0]    req_a;
    logic [N*16-1:0]    req_b;
    logic [15:0]        mul_a;
    logic [15:0]        mul_b;
    logic [31:0]        mul_c;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [1:0]         rsp_id;
    logic [31:0]        rsp_data;
    logic               busy;

    mul_rr_scheduler #(.N_REQ(N), .MUL_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // External multiplier: LAT register stages, never reset.
    logic signed [31:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= 32'($signed(mul_a)) * 32'($signed(mul_b));
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_c = mpipe[LAT-1];

    typedef struct {
        int                 id;
        logic signed [31:0] data;
        int                 due;
    } exp_t;

    exp_t q[$];
    int   last_g;
    int   cyc;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Model arbiter: first valid requester after the last winner, credit permitting.
    function automatic int pick();
        if (q.size() >= DEPTH) return -1;
        for (int k = 1; k <= N; k++) begin
            int idx = (last_g + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic step(output logic [N-1:0] acc, output logic hs);
        int                 w;
        logic               exp_v;
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic [15:0]        exp_ma;
        logic [15:0]        exp_mb;
        exp_t               e;
        @(negedge clk);
        w = pick();
        check_eq("req_ready", req_ready, (w >= 0) ? (1 << w) : 0);
        exp_v = (q.size() > 0) && (q[0].due <= cyc);
        check_eq("rsp_valid", rsp_valid, exp_v);
        if (exp_v && rsp_valid) begin
            check_eq("rsp_id", rsp_id, q[0].id);
            check_eq("rsp_data", $signed(rsp_data), q[0].data);
        end
        check_eq("busy", busy, q.size() != 0);
        hs  = exp_v && rsp_ready;
        acc = '0;
        if (hs) void'(q.pop_front());
        exp_ma = 16'd0;
        exp_mb = 16'd0;
        if (w >= 0) begin
            a = req_a[w*16 +: 16];
            b = req_b[w*16 +: 16];
            e.id   = w;
            e.data = 32'(a) * 32'(b);
            e.due  = cyc + LAT + 2;
            q.push_back(e);
            last_g = w;
            acc[w] = 1'b1;
            exp_ma = a;
            exp_mb = b;
        end
        @(posedge clk);
        cyc++;
        #1;
        check_eq("mul_a", mul_a, exp_ma);
        check_eq("mul_b", mul_b, exp_mb);
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_valid[i]       = 1'b1;
        req_a[i*16 +: 16]  = a;
        req_b[i*16 +: 16]  = b;
    endtask

    function automatic logic [15:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7fff;
            2:       return 16'hffff;
            default: return 16'($urandom());
        endcase
    endfunction

    task automatic drive_random(input logic [N-1:0] acc);
        for (int i = 0; i < N; i++) begin
            if (acc[i] || !req_valid[i]) begin
                req_valid[i]      = ($urandom_range(0, 3) != 0);
                req_a[i*16 +: 16] = rnd_operand();
                req_b[i*16 +: 16] = rnd_operand();
            end
        end
        rsp_ready = ($urandom_range(0, 9) < 7);
    endtask

    logic [N-1:0] acc;
    logic         hs;
    int           cnt;

    initial begin
        rst = 1'b0; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        cyc = 0; last_g = N - 1;
        #1;
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_mul_a", mul_a, 0);
        check_eq("rst_mul_b", mul_b, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_id", rsp_id, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        req_valid = '0;
        rst = 1'b1;

        // Single op from requester 0.
        set_op(0, 16'd25, 16'd15);
        step(acc, hs);
        req_valid = '0;
        repeat (8) step(acc, hs);

        // Round-robin with all requesters active.
        set_op(0, -16'sd25, 16'sd15);
        set_op(1, -16'sd128, -16'sd64);
        set_op(2, 16'sd123, -16'sd45);
        set_op(3, -16'sd32768, 16'sd1);
        repeat (5) step(acc, hs);
        req_valid = '0;
        repeat (10) step(acc, hs);

        // Backpressure until credit runs out, then release.
        rsp_ready = 1'b0;
        req_valid = '1;
        cnt = 0;
        repeat (14) begin
            step(acc, hs);
            if (acc != 0) cnt++;
        end
        check_eq("bp_accepts", cnt, DEPTH);
        rsp_ready = 1'b1;
        step(acc, hs);
        check_eq("bp_pop", hs, 1);
        check_eq("bp_no_accept_on_pop", acc, 0);
        step(acc, hs);
        check_eq("bp_resume", acc != 0, 1);
        repeat (12) step(acc, hs);
        req_valid = '0;
        repeat (12) step(acc, hs);

        // Extreme products.
        set_op(2, 16'h8000, 16'h8000);
        set_op(3, 16'h7fff, 16'hffff);
        repeat (2) step(acc, hs);
        req_valid = '0;
        repeat (8) step(acc, hs);

        // Reset with 3 ops in flight and 2 queued.
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (5) step(acc, hs);
        req_valid = '0;
        step(acc, hs);
        check_eq("pre_rst_rsp_valid", rsp_valid, 1);
        req_valid = '1;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_rsp_valid", rsp_valid, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_req_ready", req_ready, 0);
        q.delete();
        last_g = N - 1;
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        set_op(0, 16'd7, -16'sd6);
        step(acc, hs);
        req_valid = '0;
        cnt = 0;
        repeat (10) begin
            step(acc, hs);
            if (hs) cnt++;
        end
        check_eq("post_rst_responses", cnt, 1);

        // Randomized traffic with random backpressure.
        acc = '0;
        repeat (600) begin
            drive_random(acc);
            step(acc, hs);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (20) step(acc, hs);
        check_eq("final_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
